stopwatch_bcd: RTL and testbench

- Sequential BCD time source that sits directly upstream of the per-digit hex-to-7-segment decoders.
- Counts SS.CC (seconds 00-59, centiseconds 00-99) from the board clock.
- Provides start/stop/clear control and presents four registered 4-bit BCD digits.
- Each digit drives one decoder instance, which then drives one HEX display.

---
 rtl/stopwatch_bcd_pkg.sv | 7 +
 rtl/stopwatch_bcd_if.sv | 29 ++
 rtl/bcd_digit_cnt.sv | 17 +
 rtl/stopwatch_bcd.sv | 82 ++++++++
 tb/tb_stopwatch_bcd.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/stopwatch_bcd_pkg.sv
// stopwatch_pkg: shared BCD digit type, FSM states and digit limits for stopwatch_bcd.
package stopwatch_pkg;
    typedef logic [3:0] bcd_t;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;
    localparam bcd_t BCD_MAX      = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
endpackage

// File: rtl/stopwatch_bcd_if.sv
// stopwatch_bcd_if: button inputs and display outputs of the stopwatch.
// Lap signals exist only when STOPWATCH_LAP_EN is defined.
interface stopwatch_bcd_if;
    logic        btn_ss;
    logic        btn_clr;
    logic [15:0] digits;
    logic        running;
    logic        wrap;
`ifdef STOPWATCH_LAP_EN
    logic        btn_lap;
    logic        lap_active;
`endif
    modport master (
        output btn_ss, btn_clr,
        input  digits, running, wrap
`ifdef STOPWATCH_LAP_EN
        , output btn_lap
        , input  lap_active
`endif
    );
    modport slave (
        input  btn_ss, btn_clr,
        output digits, running, wrap
`ifdef STOPWATCH_LAP_EN
        , input  btn_lap
        , output lap_active
`endif
    );
endinterface

// File: rtl/bcd_digit_cnt.sv
// bcd_digit_cnt: one BCD digit rolling over at MAX, chained through carry.
module bcd_digit_cnt import stopwatch_pkg::*; #(
    parameter bcd_t MAX = BCD_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (inc) q <= (q == MAX) ? '0 : q + 4'd1;
    assign carry = inc && q == MAX;
endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: SS.CC BCD stopwatch with start/stop/clear.
// Optional lap-hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd import stopwatch_pkg::*; #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input logic             clk,
    input logic             rst_n,
    stopwatch_bcd_if.slave  sif
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    if (CLK_HZ % TICK_HZ != 0 || DIV < 2) begin : g_bad_cfg
        $error("stopwatch_bcd: CLK_HZ must be a multiple of TICK_HZ with DIV >= 2");
    end
    sw_state_t       state, nxt;
    logic [PW-1:0]   pre;
    logic            ss_q, clr_q, running_q, wrap_q;
    logic            ss_edge, clr_edge, tick;
    logic [3:0]      inc, c;
    bcd_t            d [4];
    logic [15:0]     live;
    assign ss_edge  = sif.btn_ss & ~ss_q;
    assign clr_edge = sif.btn_clr & ~clr_q;
    assign tick     = state == RUN && pre == PW'(DIV - 1);
    assign inc      = {c[2:0], tick};
    assign live     = {d[3], d[2], d[1], d[0]};
    always_comb begin
        nxt = state;
        nxt = clr_edge ? IDLE : ss_edge ? (state == RUN ? PAUSE : RUN) : state;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            pre       <= '0;
            ss_q      <= 1'b0;
            clr_q     <= 1'b0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state     <= nxt;
            ss_q      <= sif.btn_ss;
            clr_q     <= sif.btn_clr;
            running_q <= nxt == RUN;
            wrap_q    <= c[3] && !clr_edge;
            // PAUSE keeps the partial tick so a resume finishes it
            pre       <= (clr_edge || state == IDLE) ? '0 :
                         state == RUN ? (tick ? '0 : pre + PW'(1)) : pre;
        end
    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit_cnt #(.MAX(i == 3 ? SEC_TENS_MAX : BCD_MAX)) u_dig (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr_edge),
            .inc   (inc[i]),
            .q     (d[i]),
            .carry (c[i])
        );
    end
    assign sif.running = running_q;
    assign sif.wrap    = wrap_q;
`ifdef STOPWATCH_LAP_EN
    logic        lap_q, lap_on;
    logic [15:0] hold;
    logic        lap_edge;
    assign lap_edge = sif.btn_lap & ~lap_q & (state == RUN);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            lap_q  <= 1'b0;
            lap_on <= 1'b0;
            hold   <= '0;
        end else begin
            lap_q  <= sif.btn_lap;
            lap_on <= clr_edge ? 1'b0 : lap_edge ? ~lap_on : lap_on;
            hold   <= (lap_edge && !lap_on && !clr_edge) ? live : hold;
        end
    assign sif.lap_active = lap_on;
    assign sif.digits     = lap_on ? hold : live;
`else
    assign sif.digits = live;
`endif
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: directed plus random stimulus against a centisecond-count reference model.
module tb_stopwatch_bcd;
    localparam int DIV = 10;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0, n_bad = 0, w_cnt = 0;
    int   cs, hold, phase, mode;
    bit   ew, elap, pss, pclr, plap;

    stopwatch_bcd_if sif();
    stopwatch_bcd #(.CLK_HZ(1000), .TICK_HZ(100)) dut (.clk(clk), .rst_n(rst_n), .sif(sif));

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cs = 0; hold = 0; phase = 0; mode = 0;
        ew = 0; elap = 0; pss = 0; pclr = 0; plap = 0;
    endtask

    // mode: 0 idle, 1 run, 2 pause; cs is elapsed centiseconds 0..5999
    task automatic model_step(input bit ss, input bit clr, input bit lap);
        bit ss_e, clr_e, lap_e, tk;
        int old;
        ss_e = ss && !pss; clr_e = clr && !pclr; lap_e = LAP && lap && !plap;
        pss = ss; pclr = clr; plap = lap;
        tk = mode == 1 && phase == DIV - 1;
        old = cs;
        if (clr_e) begin
            mode = 0; cs = 0; phase = 0; ew = 0; elap = 0;
        end else begin
            ew = tk && cs == 5999;
            if (tk) cs = (cs + 1) % 6000;
            if (lap_e && mode == 1) begin
                if (!elap) hold = old;
                elap = !elap;
            end
            phase = mode == 1 ? (phase + 1) % DIV : mode == 0 ? 0 : phase;
            if (ss_e) mode = mode == 1 ? 2 : 1;
        end
    endtask

    task automatic cycle(input bit ss, input bit clr, input bit lap);
        sif.btn_ss = ss;
        sif.btn_clr = clr;
`ifdef STOPWATCH_LAP_EN
        sif.btn_lap = lap;
`endif
        model_step(ss, clr, lap);
        @(posedge clk);
        #1;
        if (sif.wrap) w_cnt++;
        check("digits", sif.digits, bcd(elap ? hold : cs));
        check("running", sif.running, mode == 1);
        check("wrap", sif.wrap, ew);
`ifdef STOPWATCH_LAP_EN
        check("lap_active", sif.lap_active, elap);
`endif
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit ss, clr, lap;
        ss = 0; clr = 0; lap = 0;
        sif.btn_ss = 0;
        sif.btn_clr = 0;
`ifdef STOPWATCH_LAP_EN
        sif.btn_lap = 0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", sif.digits, 16'h0000);
        check("rst_running", sif.running, 0);
        check("rst_wrap", sif.wrap, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(100);
        check("idle_digits", sif.digits, 16'h0000);
        cycle(1, 0, 0);
        check("start_running", sif.running, 1);
        run(1000);
        check("one_second", sif.digits, 16'h0100);
        cycle(0, 1, 0);
        check("clr_digits", sif.digits, 16'h0000);
        check("clr_running", sif.running, 0);
        repeat (50) cycle(1, 0, 0);
        check("held_ss_running", sif.running, 1);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        run(454);
        check("at_0045", sif.digits, 16'h0045);
        cycle(1, 0, 0);
        check("paused", sif.running, 0);
        run(200);
        check("pause_frozen", sif.digits, 16'h0045);
        cycle(1, 0, 0);
        run(4);
        check("resume_partial", sif.digits, 16'h0045);
        cycle(0, 0, 0);
        check("resume_tick", sif.digits, 16'h0046);
        cycle(0, 1, 0);
        w_cnt = 0;
        cycle(1, 0, 0);
        run(59999);
        check("at_5999", sif.digits, 16'h5999);
        cycle(0, 0, 0);
        check("wrap_digits", sif.digits, 16'h0000);
        check("wrap_pulse", sif.wrap, 1);
        cycle(0, 0, 0);
        check("wrap_one_cycle", sif.wrap, 0);
        check("wrap_count", w_cnt, 1);
        cycle(1, 1, 0);
        check("clr_over_ss_run", sif.running, 0);
        check("clr_over_ss_dig", sif.digits, 16'h0000);
        cycle(0, 0, 0);
`ifdef STOPWATCH_LAP_EN
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        run(12340);
        cycle(0, 0, 1);
        run(500);
        check("lap_hold", sif.digits, 16'h1234);
        check("lap_on", sif.lap_active, 1);
        cycle(0, 0, 1);
        check("lap_release", sif.digits, 16'h1284);
        check("lap_off", sif.lap_active, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        check("lap_clr", sif.lap_active, 0);
`endif
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) ss = !ss;
            clr = $urandom_range(0, 99) == 0;
            if ($urandom_range(0, 9) == 0) lap = !lap;
            if (i == 1500) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_digits", sif.digits, 16'h0000);
                check("async_rst_running", sif.running, 0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle(ss, clr, lap);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
